// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, DATA_W data bits LSB first, stop bit.
// Each bit is held for CLKS_PER_BIT clocks; tx idles high.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_nxt;
  logic [BW-1:0]     bit_q;
  logic [CW-1:0]     baud_q;
  logic              tx_q;
  logic              done_q;
  logic              baud_last;

  assign baud_last = (baud_q == BAUD_LAST);
  // Shift through a full-width temporary so DATA_W=1 never indexes past bit 0.
  assign shift_nxt = shift_q >> 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE) begin
        baud_q <= baud_last ? '0 : baud_q + CW'(1);
      end
      case (state_q)
        IDLE: begin
          if (valid) begin
            shift_q <= data_in;
            state_q <= START;
            tx_q    <= 1'b0;
            baud_q  <= '0;
          end
        end
        START: begin
          if (baud_last) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
            bit_q   <= '0;
          end
        end
        DATA: begin
          if (baud_last) begin
            if (bit_q == BIT_LAST) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              shift_q <= shift_nxt;
              tx_q    <= shift_nxt[0];
              bit_q   <= bit_q + BW'(1);
            end
          end
        end
        STOP: begin
          if (baud_last) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q != IDLE);
  assign tx    = tx_q;
  assign done  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: an 8-bit/4-clock instance driven from a frame table,
// plus a 4-bit/1-clock instance for the single-clock-per-bit case.
module tb_serial_tx;

  logic       clk = 1'b0;
  bit         clk_run = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid;
  logic       ready, tx, busy, done;
  logic [3:0] data_in2;
  logic       valid2;
  logic       ready2, tx2, busy2, done2;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 if (clk_run) clk = ~clk;

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid(valid),
    .ready(ready), .tx(tx), .busy(busy), .done(done)
  );

  serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) dut2 (
    .clk(clk), .reset(reset), .data_in(data_in2), .valid(valid2),
    .ready(ready2), .tx(tx2), .busy(busy2), .done(done2)
  );

  typedef struct {
    logic [7:0] d;
    logic [9:0] seq;     // seq[i] = i-th serial bit on the line
    bit         keep;    // hold valid high for back-to-back
    bit         inject;  // pulse valid with new data mid-frame
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Called at a negedge; the following posedge accepts the word.
  task automatic send8(input logic [7:0] d, input logic [9:0] seq,
                       input bit keep, input bit inject, input string nm);
    data_in = d;
    valid   = 1'b1;
    chk({nm, " ready"}, 32'(ready), 32'd1);
    @(negedge clk);
    if (!keep) valid = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if (inject && j == 13) begin
        data_in = 8'h3C;
        valid   = 1'b1;
      end
      if (inject && j == 14) valid = 1'b0;
      chk($sformatf("%s tx c%0d", nm, j), 32'(tx), 32'(seq[j/4]));
      chk($sformatf("%s busy/done/ready c%0d", nm, j), 32'({busy, done, ready}), 32'b100);
      @(negedge clk);
    end
    chk({nm, " done cycle tx/busy/done/ready"}, 32'({tx, busy, done, ready}), 32'b1011);
  endtask

  task automatic idle_cycles(input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("%s idle c%0d", nm, i), 32'({tx, busy, done, ready}), 32'b1001);
    end
  endtask

  initial begin
    tbl[0] = '{8'hA5, 10'b1101001010, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 10'b1000000000, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 10'b1111111110, 1'b0, 1'b0};
    tbl[3] = '{8'h81, 10'b1100000010, 1'b0, 1'b1};

    reset = 1'b1; data_in = '0; valid = 1'b0; data_in2 = '0; valid2 = 1'b0;
    #1;
    chk("reset no clk", 32'({tx, busy, done, ready}), 32'b1001);
    chk("reset no clk dut2", 32'({tx2, busy2, done2, ready2}), 32'b1001);

    clk_run = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(10, "post reset");

    for (int i = 0; i < 4; i++) begin
      send8(tbl[i].d, tbl[i].seq, tbl[i].keep, tbl[i].inject, $sformatf("frame%0d", i));
      if (!tbl[i].keep) idle_cycles(3, $sformatf("after frame%0d", i));
    end

    // Reset during data bit 3 (cycles 16..19 after acceptance).
    data_in = 8'hC3;
    valid   = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (17) @(negedge clk);
    chk("pre-reset busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1 chk("mid-frame reset", 32'({tx, busy, done, ready}), 32'b1001);
    @(negedge clk);
    chk("held reset", 32'({tx, busy, done, ready}), 32'b1001);
    reset = 1'b0;
    idle_cycles(5, "after abort");
    send8(8'h5A, 10'b1010110100, 1'b0, 1'b0, "frame 5A");
    idle_cycles(2, "after 5A");

    // CLKS_PER_BIT=1, DATA_W=4, word 0x6.
    data_in2 = 4'h6;
    valid2   = 1'b1;
    chk("dut2 ready", 32'(ready2), 32'd1);
    @(negedge clk);
    valid2 = 1'b0;
    begin
      logic [5:0] seq2;
      seq2 = 6'b101100;
      for (int j = 0; j < 6; j++) begin
        chk($sformatf("dut2 tx c%0d", j), 32'(tx2), 32'(seq2[j]));
        chk($sformatf("dut2 busy/done c%0d", j), 32'({busy2, done2}), 32'b10);
        @(negedge clk);
      end
    end
    chk("dut2 done cycle", 32'({tx2, busy2, done2, ready2}), 32'b1011);
    @(negedge clk);
    chk("dut2 after done", 32'({tx2, busy2, done2, ready2}), 32'b1001);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
